vga_out_stage: RTL
==================

# vga_out_stage

Parametrised VGA output stage that sits between the renderer core and the top-level pad wrapper. It reduces per-channel colour depth with optional 2×2 ordered dithering and forces black during blanking. It also offers a selectable registered path of configurable depth. Mode changes are synchronised and take effect only at the start of vertical blanking, so a live frame never tears.

## Interface
Parameters:
- IN_BPC, 8, input bits per channel; constraint IN_BPC ≥ OUT_BPC + 2.
- OUT_BPC, 2, output bits per channel.
- PIPE_DEPTH, 1, register stages on the registered path; range 1..4.

Ports:
- clk  in  1  single design clock.
- reset  in  1  asynchronous, active-high reset.
- i_rgb  in  3*IN_BPC  colour, packed {R,G,B}.
- i_hsync_n, i_vsync_n  in  1 each  active-low syncs from the timing generator.
- i_hblank, i_vblank  in  1 each  blanking flags.
- i_reg_mode  in  1  path select, asynchronous pin: 0 = combinational, 1 = registered.
- i_dither_en  in  1  dither enable, quasi-static; sampled each cycle.
- o_rgb  out  3*OUT_BPC  colour, packed {R,G,B}.
- o_hsync_n, o_vsync_n, o_hblank, o_vblank  out  1 each  aligned with o_rgb.
- o_mode  out  1  currently applied path mode.

## Operation
- **Mode synchroniser**
  - i_reg_mode passes through 2 flops to give mode_sync.
  - A registered copy of i_vblank (vb_q) is kept.
  - On the cycle where i_vblank=1 and vb_q=0, o_mode ← mode_sync.
  - At all other times o_mode holds.
- **Parity tracking**
  - x_par resets to 0 while i_hblank=1, and toggles each cycle while i_hblank=0.
  - y_par resets to 0 while i_vblank=1, and toggles on each i_hblank 0→1 edge while i_vblank=0.
- **Per-channel colour**
  - Threshold t = Bayer[{y_par,x_par}] with values 00→0, 01→2, 10→3, 11→1.
  - Dithered value: sum = c + (t << (IN_BPC−OUT_BPC−2)), computed IN_BPC+1 wide, saturated to 2^IN_BPC−1, then reduced to its top OUT_BPC bits.
  - When dither is disabled, the output is the top OUT_BPC bits of c.
- **Blank enforcement:** if i_hblank or i_vblank is 1, the colour is 0 before the path mux.
- **Path mux**
  - o_mode=0: outputs are a combinational function of current inputs and the parity registers.
  - o_mode=1: colour, syncs and blanks all pass through PIPE_DEPTH identical register stages.
  - The pipeline is always clocked, even in mode 0.
- **Mode switch effect:** sync edges shift by PIPE_DEPTH cycles once, during vblank. This is accepted; the colour stays black.

## Timing
- **Reset values**
  - Pipeline stages: rgb=0, sync_n=1, blank=1.
  - o_mode=0; sync flops 0; vb_q=1; x_par=y_par=0.
- **Outputs during reset:** mode 0 is in force, so outputs follow the inputs combinationally (blank-forced).
- **Latency**
  - Mode 0: 0 cycles.
  - Mode 1: PIPE_DEPTH cycles for all outputs; syncs and blanks are never skewed against colour.
- **Mode pin to o_mode:** ≥2 cycles after a pin change, plus the wait for the next vblank rising edge.
  - If the pin changes within 2 cycles of that edge, the old value may be applied; the new value lands at the following frame.
- **Reset mid-frame:** parities clear; the first line after reset starts at x_par=0.
- **Simultaneous hblank edge and vblank rising edge:** vblank wins, so y_par becomes 0.

## Configuration
- **VGA_OUT_DITHER_EN defined:** dither logic is built and i_dither_en is honoured.
- **VGA_OUT_DITHER_EN undefined**
  - Parity registers and adders are omitted; output is truncation only.
  - i_dither_en stays as a port but is ignored.
  - Port list is identical in both builds.

## Structure
- Package vga_out_pkg holds:
  - the Bayer 2×2 threshold constant array;
  - the mode encoding constants MODE_COMB=0 and MODE_REG=1;
  - a localparam helper for the threshold shift.
- Sub-module vga_out_dither: one channel of add/saturate/truncate plus the blank force, instantiated three times.
- Parity tracking, mode sync and the pipeline stay in the top level.

## Test plan
All scenarios use defaults IN_BPC=8, OUT_BPC=2.
- **Reset:** reset=1 mid-stream → o_mode=0, the pipeline holds rgb=0 / sync_n=1 / blank=1; the mode-0 output equals the blank-forced inputs.
- **Truncation, dither off**
  - i_rgb={0xFF,0x80,0x3F}, no blank → o_rgb={3,2,0} in the same cycle.
  - Hold i_hblank=1 → o_rgb=0.
- **Dither on, c=0x50 every active pixel**
  - Line 0 alternates 1 (t=0) and 1 (t=2, sum 112→1).
  - Line 1: t=3 gives 128→2, t=1 gives 96→1.
  - c=0xF0 at t=3 → saturates to 255 → output 3, with no wrap to 0.
- **Mode switch:** set i_reg_mode=1 mid-frame → o_mode stays 0 until the first vblank rise ≥2 cycles later. After that, all outputs lag the inputs by exactly PIPE_DEPTH=1 cycle, and sync and colour stay aligned.
- **Build without VGA_OUT_DITHER_EN:** i_dither_en=1 with c=0x50 → every pixel gives 1.
- **PIPE_DEPTH=3 build:** a sync pulse appears on o_hsync_n exactly 3 cycles after i_hsync_n, with matching o_hblank.

Source files
------------

// File: rtl/vga_out_pkg.sv
// vga_out_pkg
// Shared constants for the VGA output stage:
//   BAYER        - 2x2 ordered-dither thresholds, indexed by {y_par, x_par}
//   MODE_COMB    - output path select value for the combinational path
//   MODE_REG     - output path select value for the registered path
//   thresh_shift - left shift that scales a 2-bit threshold up to the
//                  weight of the bits that truncation throws away
package vga_out_pkg;

  localparam logic MODE_COMB = 1'b0;
  localparam logic MODE_REG  = 1'b1;

  // Element 0 is the rightmost entry: {y,x}=00->0, 01->2, 10->3, 11->1
  localparam logic [3:0][1:0] BAYER = {2'd1, 2'd3, 2'd2, 2'd0};

  function automatic int thresh_shift(input int in_bpc, input int out_bpc);
    return in_bpc - out_bpc - 2;
  endfunction

endpackage

// File: rtl/vga_out_dither.sv
// vga_out_dither
// One colour channel: optional threshold add with saturation, reduction to
// OUT_BPC bits, and forcing to black during blanking.
// Build option: VGA_OUT_DITHER_EN (when undefined the adder is not built and
// t / dither are ignored, leaving plain truncation).
// Ports:
//   c      in  IN_BPC   input channel value
//   t      in  2        Bayer threshold for the current pixel
//   dither in  1        apply the threshold before reduction
//   blank  in  1        force the result to 0
//   q      out OUT_BPC  reduced channel value
module vga_out_dither
  import vga_out_pkg::*;
#(
  parameter int IN_BPC  = 8,
  parameter int OUT_BPC = 2
) (
  input  logic [IN_BPC-1:0]  c,
  input  logic [1:0]         t,
  input  logic               dither,
  input  logic               blank,
  output logic [OUT_BPC-1:0] q
);

  localparam int DROP = IN_BPC - OUT_BPC;

`ifdef VGA_OUT_DITHER_EN
  localparam int SHIFT = thresh_shift(IN_BPC, OUT_BPC);

  logic [IN_BPC:0]      sum;
  logic [OUT_BPC-1:0]   dith_q;
  logic                 unused_low;

  // The sum is one bit wider than the channel so a carry out can be seen
  // and clamped to full scale instead of wrapping back to black.
  always_comb begin
    sum    = {1'b0, c} + ({{(IN_BPC-1){1'b0}}, t} << SHIFT);
    dith_q = sum[IN_BPC] ? '1 : sum[IN_BPC-1 -: OUT_BPC];
  end

  assign unused_low = ^sum[DROP-1:0];

  always_comb begin
    if (blank)       q = '0;
    else if (dither) q = dith_q;
    else             q = c[IN_BPC-1 -: OUT_BPC];
  end
`else
  logic unused_in;

  assign unused_in = ^{c[DROP-1:0], t, dither};
  assign q         = blank ? '0 : c[IN_BPC-1 -: OUT_BPC];
`endif

endmodule

// File: rtl/vga_out_stage.sv
// vga_out_stage
// VGA output stage between the renderer and the pad wrapper. Reduces colour
// depth (optionally with 2x2 ordered dither), blacks out blanking, and offers
// a PIPE_DEPTH-stage registered path. Path changes are applied only at the
// rising edge of vblank so a visible frame never tears.
// Build option: VGA_OUT_DITHER_EN builds the parity trackers and dither
// adders; without it the output is truncation only and i_dither_en is ignored.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   i_rgb                       packed {R,G,B}, IN_BPC per channel
//   i_hsync_n, i_vsync_n        active-low syncs
//   i_hblank, i_vblank          blanking flags
//   i_reg_mode                  asynchronous path select (1 = registered)
//   i_dither_en                 dither enable, sampled every cycle
//   o_rgb                       packed {R,G,B}, OUT_BPC per channel
//   o_hsync_n ... o_vblank      syncs and blanks aligned with o_rgb
//   o_mode                      path mode currently applied
module vga_out_stage
  import vga_out_pkg::*;
#(
  parameter int IN_BPC     = 8,
  parameter int OUT_BPC    = 2,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3*IN_BPC-1:0]  i_rgb,
  input  logic                 i_hsync_n,
  input  logic                 i_vsync_n,
  input  logic                 i_hblank,
  input  logic                 i_vblank,
  input  logic                 i_reg_mode,
  input  logic                 i_dither_en,
  output logic [3*OUT_BPC-1:0] o_rgb,
  output logic                 o_hsync_n,
  output logic                 o_vsync_n,
  output logic                 o_hblank,
  output logic                 o_vblank,
  output logic                 o_mode
);

  localparam int RGB_W = 3 * OUT_BPC;

  logic                  mode_meta;
  logic                  mode_sync;
  logic                  vb_q;
  logic [1:0]            thresh;
  logic                  dither;
  logic                  blank;
  logic [RGB_W-1:0]      comb_rgb;
  logic [RGB_W-1:0]      pipe_rgb [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] pipe_hs;
  logic [PIPE_DEPTH-1:0] pipe_vs;
  logic [PIPE_DEPTH-1:0] pipe_hb;
  logic [PIPE_DEPTH-1:0] pipe_vb;

  // Two-flop synchroniser for the mode pin; the synchronised value is only
  // committed on the first cycle of vblank, when the colour is already black.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_meta <= 1'b0;
      mode_sync <= 1'b0;
      vb_q      <= 1'b1;
      o_mode    <= MODE_COMB;
    end else begin
      mode_meta <= i_reg_mode;
      mode_sync <= mode_meta;
      vb_q      <= i_vblank;
      if (i_vblank && !vb_q)
        o_mode <= mode_sync;
    end
  end

`ifdef VGA_OUT_DITHER_EN
  logic x_par;
  logic y_par;
  logic hb_q;

  // Pixel parity restarts in every hblank; line parity restarts in vblank and
  // advances at the start of each hblank. vblank takes priority when both
  // happen together, so the first line of a frame is always line parity 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_par <= 1'b0;
      y_par <= 1'b0;
      hb_q  <= 1'b1;
    end else begin
      hb_q  <= i_hblank;
      x_par <= i_hblank ? 1'b0 : ~x_par;
      if (i_vblank)
        y_par <= 1'b0;
      else if (i_hblank && !hb_q)
        y_par <= ~y_par;
    end
  end

  assign thresh = BAYER[{y_par, x_par}];
  assign dither = i_dither_en;
`else
  logic unused_dither_en;

  assign unused_dither_en = i_dither_en;
  assign thresh           = 2'd0;
  assign dither           = 1'b0;
`endif

  assign blank = i_hblank | i_vblank;

  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    vga_out_dither #(
      .IN_BPC (IN_BPC),
      .OUT_BPC(OUT_BPC)
    ) u_chan (
      .c     (i_rgb[ch*IN_BPC +: IN_BPC]),
      .t     (thresh),
      .dither(dither),
      .blank (blank),
      .q     (comb_rgb[ch*OUT_BPC +: OUT_BPC])
    );
  end

  // Colour, syncs and blanks share the same delay line so they can never be
  // skewed against each other; it runs continuously so switching into the
  // registered path needs no warm-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) pipe_rgb[i] <= '0;
      pipe_hs <= '1;
      pipe_vs <= '1;
      pipe_hb <= '1;
      pipe_vb <= '1;
    end else begin
      pipe_rgb[0] <= comb_rgb;
      pipe_hs[0]  <= i_hsync_n;
      pipe_vs[0]  <= i_vsync_n;
      pipe_hb[0]  <= i_hblank;
      pipe_vb[0]  <= i_vblank;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_rgb[i] <= pipe_rgb[i-1];
        pipe_hs[i]  <= pipe_hs[i-1];
        pipe_vs[i]  <= pipe_vs[i-1];
        pipe_hb[i]  <= pipe_hb[i-1];
        pipe_vb[i]  <= pipe_vb[i-1];
      end
    end
  end

  always_comb begin
    if (o_mode == MODE_REG) begin
      o_rgb     = pipe_rgb[PIPE_DEPTH-1];
      o_hsync_n = pipe_hs[PIPE_DEPTH-1];
      o_vsync_n = pipe_vs[PIPE_DEPTH-1];
      o_hblank  = pipe_hb[PIPE_DEPTH-1];
      o_vblank  = pipe_vb[PIPE_DEPTH-1];
    end else begin
      o_rgb     = comb_rgb;
      o_hsync_n = i_hsync_n;
      o_vsync_n = i_vsync_n;
      o_hblank  = i_hblank;
      o_vblank  = i_vblank;
    end
  end

endmodule
